// File: rtl/amber_wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
package amber_wb_arb_pkg;

  // Default bus geometry for the Amber memory port.
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  // Arbiter FSM: idle, or the bus owned by master 0 or master 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // One-hot grant encoding presented on o_grant.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage : amber_wb_arb_pkg

// File: rtl/amber_wb_arb_watchdog.sv
// Stall watchdog: counts strobe cycles without a slave termination and flags a
// timeout on the TIMEOUT-th such cycle. Only built with AMBER_WB_ARB_TIMEOUT_EN.
module amber_wb_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,      // owner's strobe before timeout masking
  input  logic i_ack,
  input  logic i_err,
  input  logic i_clr,      // grant is about to change
  output logic o_timeout
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;
  logic             w_hit;

  // A stalled strobe is one the slave has not terminated this cycle; an ack on
  // the final count cycle suppresses the timeout so the real response wins.
  assign w_stall   = i_stb & ~i_ack & ~i_err;
  assign w_hit     = w_stall && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign o_timeout = w_hit;

  // Stall counter: clears on any termination, grant change or timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || i_ack || i_err || w_hit) begin
      r_cnt <= '0;
    end else if (w_stall) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : amber_wb_arb_watchdog

// File: rtl/amber_wb_rr_arbiter.sv
// Two-master, one-slave Wishbone round-robin arbiter with cycle-locked grants.
// Optional stall watchdog enabled by defining AMBER_WB_ARB_TIMEOUT_EN.
module amber_wb_rr_arbiter
  import amber_wb_arb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  // Master 0
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic [DW-1:0]   o_m0_dat,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  // Master 1
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic [DW-1:0]   o_m1_dat,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  // Slave
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_adr,
  output logic [DW-1:0]   o_s_dat,
  output logic [DW/8-1:0] o_s_sel,
  input  logic [DW-1:0]   i_s_dat,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  // Current owner
  output logic [1:0]      o_grant
);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("amber_wb_rr_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_gnt;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_stb_raw;
  logic       w_timeout;

  // Next-state: hold while the owner keeps CYC, hand over directly on release.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch forms.
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) w_next_state = r_last_gnt ? GNT0 : GNT1;
        else if (i_m0_cyc)        w_next_state = GNT0;
        else if (i_m1_cyc)        w_next_state = GNT1;
      end
      GNT0: begin
        if (!i_m0_cyc) w_next_state = i_m1_cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!i_m1_cyc) w_next_state = i_m0_cyc ? GNT0 : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State and last-granted master; reset makes M0 win the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == GNT0)      r_last_gnt <= 1'b0;
      else if (w_next_state == GNT1) r_last_gnt <= 1'b1;
    end
  end

  assign w_gnt0  = (r_state == GNT0);
  assign w_gnt1  = (r_state == GNT1);
  assign o_grant = w_gnt0 ? GRANT_M0 : (w_gnt1 ? GRANT_M1 : GRANT_NONE);

  // Forward mux: owner's request straight to the slave, all zero when idle.
  always_comb begin
    o_s_cyc   = 1'b0;
    w_stb_raw = 1'b0;
    o_s_we    = 1'b0;
    o_s_adr   = '0;
    o_s_dat   = '0;
    o_s_sel   = '0;
    if (w_gnt0) begin
      o_s_cyc   = i_m0_cyc;
      w_stb_raw = i_m0_stb;
      o_s_we    = i_m0_we;
      o_s_adr   = i_m0_adr;
      o_s_dat   = i_m0_dat;
      o_s_sel   = i_m0_sel;
    end else if (w_gnt1) begin
      o_s_cyc   = i_m1_cyc;
      w_stb_raw = i_m1_stb;
      o_s_we    = i_m1_we;
      o_s_adr   = i_m1_adr;
      o_s_dat   = i_m1_dat;
      o_s_sel   = i_m1_sel;
    end
  end

`ifdef AMBER_WB_ARB_TIMEOUT_EN
  amber_wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_stb     (w_stb_raw),
    .i_ack     (i_s_ack),
    .i_err     (i_s_err),
    .i_clr     (w_next_state != r_state),
    .o_timeout (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // The aborted strobe is withdrawn in the same cycle the owner sees err.
  assign o_s_stb = w_stb_raw & ~w_timeout;

  // Return path: data is broadcast, terminations go only to the owner.
  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;
  assign o_m0_ack = w_gnt0 & i_s_ack;
  assign o_m1_ack = w_gnt1 & i_s_ack;
  assign o_m0_err = w_gnt0 & (i_s_err | w_timeout);
  assign o_m1_err = w_gnt1 & (i_s_err | w_timeout);

endmodule : amber_wb_rr_arbiter

// File: tb/tb_amber_wb_rr_arbiter.sv
// Directed self-checking bench for amber_wb_rr_arbiter. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
module tb_amber_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  amber_wb_rr_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
    .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack),
    .o_m0_err(m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
    .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack),
    .o_m1_err(m1_err),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
    .o_s_dat(s_wdat), .o_s_sel(s_sel), .i_s_dat(s_rdat), .i_s_ack(s_ack),
    .i_s_err(s_err), .o_grant(grant)
  );

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  // Hold reset across two edges, release it mid-cycle.
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200; m1_sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++;
    if ({s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel} !== '0) begin
      failures++; $display("FAIL reset_slave_idle: cyc=%b stb=%b adr=%h want all 0", s_cyc, s_stb, s_adr);
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      failures++; $display("FAIL reset_term: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL reset_first_grant: got %b want 01", grant); end
    checks++;
    if (s_adr !== 32'h0000_0100 || s_cyc !== 1'b1 || s_stb !== 1'b1) begin
      failures++; $display("FAIL reset_first_adr: adr=%h cyc=%b stb=%b want 00000100 1 1", s_adr, s_cyc, s_stb);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || s_adr !== 32'h0000_0100) begin
      failures++; $display("FAIL reset_m1_held: grant=%b adr=%h want 01 00000100", grant, s_adr);
    end
  endtask

  task automatic test_single_read();
    clear_inputs();
    apply_reset();
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0300; m0_sel = 4'hF;
    @(negedge clk);
    checks++;
    if (s_cyc !== 1'b0 || grant !== 2'b00) begin
      failures++; $display("FAIL read_latency: cyc=%b grant=%b want 0 00", s_cyc, grant);
    end
    next_cycle();
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (s_adr !== 32'h0000_0300 || s_we !== 1'b0 || s_sel !== 4'hF) begin
      failures++; $display("FAIL read_fwd: adr=%h we=%b sel=%h want 00000300 0 f", s_adr, s_we, s_sel);
    end
    checks++;
    if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL read_ack: ack=%b dat=%h want 1 deadbeef", m0_ack, m0_rdat);
    end
    checks++;
    if (m1_ack !== 1'b0 || m1_err !== 1'b0 || m0_err !== 1'b0) begin
      failures++; $display("FAIL read_other_term: m1_ack=%b m1_err=%b m0_err=%b want 0 0 0", m1_ack, m1_err, m0_err);
    end
    next_cycle();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    @(negedge clk);
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL read_release_cyc: got %b want 0", s_cyc); end
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL read_idle: got %b want 00", grant); end
  endtask

  task automatic test_burst();
    clear_inputs();
    apply_reset();
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_1000; m0_dat = 32'h1111_0000; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_2000; m1_sel = 4'h3;
    next_cycle();
    for (int beat = 0; beat < 4; beat++) begin
      s_ack = 1; m0_adr = 32'h0000_1000 + 32'(beat * 4);
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
        failures++; $display("FAIL burst_beat%0d: grant=%b m0_ack=%b m1_ack=%b want 01 1 0", beat, grant, m0_ack, m1_ack);
      end
      checks++;
      if (s_adr !== 32'h0000_1000 + 32'(beat * 4) || s_we !== 1'b1) begin
        failures++; $display("FAIL burst_adr%0d: adr=%h we=%b", beat, s_adr, s_we);
      end
      next_cycle();
    end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL burst_drop_cycle: got %b want 01", grant); end
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || s_cyc !== 1'b1 || s_adr !== 32'h0000_2000 || s_sel !== 4'h3) begin
      failures++; $display("FAIL burst_handover: grant=%b cyc=%b adr=%h sel=%h want 10 1 00002000 3", grant, s_cyc, s_adr, s_sel);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] seq [$];
    int  rem0 = 3, rem1 = 3;
    bit  acked0 = 0, acked1 = 0;
    clear_inputs();
    apply_reset();
    m0_adr = 32'h0000_0A00; m1_adr = 32'h0000_0B00;
    for (int n = 0; n < 40 && (rem0 > 0 || rem1 > 0); n++) begin
      next_cycle();
      m0_cyc = (rem0 > 0) && !acked0; m0_stb = m0_cyc;
      m1_cyc = (rem1 > 0) && !acked1; m1_stb = m1_cyc;
      #1 s_ack = s_stb;
      @(negedge clk);
      acked0 = m0_ack; acked1 = m1_ack;
      if (m0_ack) begin rem0--; seq.push_back(grant); end
      if (m1_ack) begin rem1--; seq.push_back(grant); end
    end
    next_cycle();
    clear_inputs();
    checks++;
    if (seq.size() != 6) begin
      failures++; $display("FAIL b2b_count: got %0d acks want 6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] !== exp_seq[i]) begin
          failures++; $display("FAIL b2b_grant%0d: got %b want %b", i, seq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    apply_reset();
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_0C00; m0_dat = 32'hCAFE_0001;
    m1_cyc = 1; m1_stb = 1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (s_stb !== 1'b1 || grant !== 2'b01) begin
      failures++; $display("FAIL arst_pre: stb=%b grant=%b want 1 01", s_stb, grant);
    end
    #2 rst = 1'b1; s_ack = 1'b1;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || grant !== 2'b00) begin
      failures++; $display("FAIL arst_drop: cyc=%b stb=%b grant=%b want 0 0 00", s_cyc, s_stb, grant);
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      failures++; $display("FAIL arst_term: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

`ifdef AMBER_WB_ARB_TIMEOUT_EN
  // Stall from the first strobe cycle; the 16th stalled cycle is the abort.
  task automatic test_timeout(input bit ack_on_last);
    clear_inputs();
    apply_reset();
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0D00;
    next_cycle();
    for (int k = 1; k <= 17; k++) begin
      s_ack = ack_on_last && (k == 16);
      @(negedge clk);
      if (k < 16 || k == 17) begin
        checks++;
        if (m0_err !== 1'b0 || s_stb !== 1'b1) begin
          failures++; $display("FAIL wdog_stall%0d: err=%b stb=%b want 0 1", k, m0_err, s_stb);
        end
      end else begin
        checks++;
        if (m0_err !== !ack_on_last || m0_ack !== ack_on_last || s_stb !== ack_on_last) begin
          failures++; $display("FAIL wdog_hit ack_case=%0d: err=%b ack=%b stb=%b", ack_on_last, m0_err, m0_ack, s_stb);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_burst();
    test_back_to_back();
    test_async_reset();
`ifdef AMBER_WB_ARB_TIMEOUT_EN
    test_timeout(1'b0);
    test_timeout(1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_amber_wb_rr_arbiter

// File: doc/amber_wb_rr_arbiter.md
# amber_wb_rr_arbiter

Two-master, one-slave Wishbone arbiter that shares the Amber core's memory port (o_wb_*/i_wb_*) with a second master, such as a program loader or DMA engine, on the same bus. Arbitration is round-robin and cycle-locked: a master keeps the grant for as long as it holds CYC, so block transfers are never split. The block sits between the core's Wishbone master port and the single memory/peripheral slave.

## Interface
- AW, 32, address width
- DW, 32, data width; select width is DW/8
- TIMEOUT, 16, cycles an STB may wait for ACK/ERR before the watchdog aborts it (watchdog build only)
- i_clk  input  1  bus clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_mN_cyc, i_mN_stb, i_mN_we  input  1 each  master N (N=0,1) cycle, strobe, write enable
- i_mN_adr  input  AW  master N address
- i_mN_dat  input  DW  master N write data
- i_mN_sel  input  DW/8  master N byte selects
- o_mN_dat  output  DW  read data to master N
- o_mN_ack, o_mN_err  output  1 each  termination to master N
- o_s_cyc, o_s_stb, o_s_we  output  1 each  slave cycle, strobe, write enable
- o_s_adr  output  AW; o_s_dat  output  DW; o_s_sel  output  DW/8
- i_s_dat  input  DW; i_s_ack, i_s_err  input  1 each
- o_grant  output  2  one-hot current owner (00 = idle)

## Operation
- FSM states: IDLE, GNT0, GNT1. Register last_gnt holds the most recently granted master.
- IDLE: exactly one cyc high -> grant that master. Both high -> grant the master that is not last_gnt.
- GNTx: stay while i_mx_cyc=1, regardless of stb/ack activity.
- GNTx with i_mx_cyc=0: if the other master's cyc=1, move directly to GNTy; otherwise go to IDLE.
- Each transition into GNTx sets last_gnt=x.
- Forward path: when granted, o_s_* equal the owner's inputs combinationally. In IDLE, all o_s_* are 0.
- Return path: o_mx_dat = i_s_dat for both masters. o_mx_ack/err = i_s_ack/err gated by grant. The non-owner always sees ack=err=0.
- A non-granted master's stb is ignored and it receives no termination. It waits with cyc held.

## Timing
- Reset: state=IDLE, last_gnt=1 so M0 wins the first tie. o_grant=00, all o_s_* = 0, all o_m*_ack/err = 0, watchdog count = 0. All apply immediately on assertion.
- Reset mid-transfer: the cycle is dropped with no termination to the master. The master must restart after reset.
- Grant latency: master cyc rises in cycle N -> o_s_cyc/stb are driven in cycle N+1.
- ACK/ERR latency through the arbiter: 0 cycles (combinational).
- Handover: owner drops cyc in cycle N, other master waiting -> the new owner drives the slave in cycle N+1. There is no dead cycle.
- Both masters continuously requesting with single-access cycles: grants alternate 0,1,0,1.

## Configuration
- AMBER_WB_ARB_TIMEOUT_EN defined:
  - Watchdog counts cycles where o_s_stb=1 and i_s_ack=i_s_err=0.
  - On reaching TIMEOUT-1 it asserts o_mx_err for one cycle to the owner and forces o_s_stb=0 that cycle.
  - The count clears on ack, err, grant change, or timeout.
  - If ack arrives in the same cycle as the timeout, ack wins and no err is sent.
- AMBER_WB_ARB_TIMEOUT_EN not defined: no counter is built, TIMEOUT is unused, and a stalled slave blocks the bus indefinitely.

## Structure
- Package amber_wb_arb_pkg holds:
  - arb_state_t enum (IDLE, GNT0, GNT1)
  - WB_AW/WB_DW default constants
  - the grant-encoding localparams
- Sub-module amber_wb_arb_watchdog holds the timeout counter. It is instantiated only under AMBER_WB_ARB_TIMEOUT_EN.
- The top level contains the FSM, last_gnt and the muxes.

## Test plan
- Reset with both cyc=1 -> after reset release, o_grant=01 in the first cycle. o_s_adr equals i_m0_adr (0x0000_0100), while M1 (adr 0x0000_0200) is held off.
- M0 single read, slave acks with 0xDEAD_BEEF -> o_m0_ack=1 and o_m0_dat=0xDEAD_BEEF in the same cycle. o_m1_ack stays 0.
- M0 holds cyc through a 4-beat burst while M1 requests -> o_grant stays 01 for all 4 acks. It becomes 10 the cycle after M0 drops cyc, with no idle cycle.
- Both masters issue 6 back-to-back single cycles -> the o_grant sequence is 01,10,01,10,01,10.
- Async i_rst pulse mid-write (stb=1, no ack yet) -> o_s_cyc=o_s_stb=0 and o_grant=00 immediately. No ack or err is sent to either master.
- With AMBER_WB_ARB_TIMEOUT_EN and TIMEOUT=16, slave never acks -> o_m0_err pulses for one cycle 16 cycles after stb. Repeat with ack on cycle 16 -> ack only, no err.
